// File: rtl/pooling_layer.sv
// pooling_layer
//   2x2, stride-2 max or average pooling over a set of square feature maps held
//   in a shared memory. Each pooled word takes six cycles: four window reads,
//   one cycle to absorb the last read word, and one write.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   enable        start request, level-sampled in IDLE
//   poolMode      0 = max, 1 = average
//   mapsNumber    number of input maps
//   mapSize       input map side S (output side is S >> 1)
//   inAddress     base of map 0 (maps contiguous, row-major)
//   outAddress    base of pooled output
//   readEnable / readAddr / readData    memory read port, data one cycle after strobe
//   writeEnable / writeAddr / writeOut  memory write port
//   done          one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for enable, latches configuration
// ISSUE0 | read window word 0 (B)
// ISSUE1 | read word 1 (B+1), capture word 0
// ISSUE2 | read word 2 (B+S), merge word 1
// ISSUE3 | read word 3 (B+S+1), merge word 2
// LAST   | merge word 3, result goes to the output register
// WRITE  | write pooled word, advance to next element
// DONE   | done pulse
// HOLD   | wait for enable to drop
module pooling_layer #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               poolMode,
    input  logic [DATA_SZ-1:0] mapsNumber,
    input  logic [DATA_SZ-1:0] mapSize,
    input  logic [ADDR_SZ-1:0] inAddress,
    input  logic [ADDR_SZ-1:0] outAddress,
    output logic               readEnable,
    output logic [ADDR_SZ-1:0] readAddr,
    input  logic [DATA_SZ-1:0] readData,
    output logic               writeEnable,
    output logic [ADDR_SZ-1:0] writeAddr,
    output logic [DATA_SZ-1:0] writeOut,
    output logic               done
);

    typedef enum logic [3:0] {
        S_IDLE, S_ISSUE0, S_ISSUE1, S_ISSUE2, S_ISSUE3,
        S_LAST, S_WRITE, S_DONE, S_HOLD
    } state_t;

    state_t state_q, state_d;

    // latched configuration
    logic               mode_q, mode_d;
    logic [DATA_SZ-1:0] maps_q, maps_d;
    logic [ADDR_SZ-1:0] size_q, size_d;      // S in the address domain
    logic [DATA_SZ-1:0] osz_q, osz_d;        // O = S >> 1
    logic [ADDR_SZ-1:0] sq_q, sq_d;          // S*S, distance between map bases

    // traversal counters and running addresses
    logic [DATA_SZ-1:0] col_q, col_d;
    logic [DATA_SZ-1:0] row_q, row_d;
    logic [DATA_SZ-1:0] map_q, map_d;
    logic [ADDR_SZ-1:0] base_q, base_d;      // window top-left address B
    logic [ADDR_SZ-1:0] row_base_q, row_base_d;
    logic [ADDR_SZ-1:0] map_base_q, map_base_d;
    logic [ADDR_SZ-1:0] wr_ptr_q, wr_ptr_d;

    // running max or sum of the window
    logic signed [DATA_SZ+1:0] acc_q, acc_d;

    // registered outputs
    logic               re_q, re_d;
    logic [ADDR_SZ-1:0] ra_q, ra_d;
    logic               we_q, we_d;
    logic [ADDR_SZ-1:0] wa_q, wa_d;
    logic [DATA_SZ-1:0] wo_q, wo_d;
    logic               done_q, done_d;

    logic                      degenerate;
    logic                      col_last, row_last, map_last, last_elem;
    logic signed [DATA_SZ+1:0] rd_ext;
    logic signed [DATA_SZ+1:0] merged;
    logic        [DATA_SZ-1:0] result;

    assign degenerate = (mapsNumber == '0) || (mapSize < DATA_SZ'(2));
    assign col_last   = (col_q + DATA_SZ'(1)) == osz_q;
    assign row_last   = (row_q + DATA_SZ'(1)) == osz_q;
    assign map_last   = (map_q + DATA_SZ'(1)) == maps_q;
    assign last_elem  = col_last && row_last && map_last;

    // two guard bits: the sum of four words always fits, so the average never overflows
    assign rd_ext = {{2{readData[DATA_SZ-1]}}, readData};
    assign merged = mode_q ? (acc_q + rd_ext) : ((rd_ext > acc_q) ? rd_ext : acc_q);
    assign result = mode_q ? DATA_SZ'(merged >>> 2) : DATA_SZ'(merged);

    // ------------------------------------------------------------------
    // state register (plus all datapath and output flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            maps_q     <= '0;
            size_q     <= '0;
            osz_q      <= '0;
            sq_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            map_q      <= '0;
            base_q     <= '0;
            row_base_q <= '0;
            map_base_q <= '0;
            wr_ptr_q   <= '0;
            acc_q      <= '0;
            re_q       <= 1'b0;
            ra_q       <= '0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            maps_q     <= maps_d;
            size_q     <= size_d;
            osz_q      <= osz_d;
            sq_q       <= sq_d;
            col_q      <= col_d;
            row_q      <= row_d;
            map_q      <= map_d;
            base_q     <= base_d;
            row_base_q <= row_base_d;
            map_base_q <= map_base_d;
            wr_ptr_q   <= wr_ptr_d;
            acc_q      <= acc_d;
            re_q       <= re_d;
            ra_q       <= ra_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wo_q       <= wo_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable) state_d = degenerate ? S_DONE : S_ISSUE0;
            S_ISSUE0: state_d = S_ISSUE1;
            S_ISSUE1: state_d = S_ISSUE2;
            S_ISSUE2: state_d = S_ISSUE3;
            S_ISSUE3: state_d = S_LAST;
            S_LAST:   state_d = S_WRITE;
            S_WRITE:  state_d = last_elem ? S_DONE : S_ISSUE0;
            S_DONE:   state_d = S_HOLD;
            S_HOLD:   if (!enable) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // datapath: configuration latch, traversal, window accumulation
    // ------------------------------------------------------------------
    always_comb begin
        mode_d     = mode_q;
        maps_d     = maps_q;
        size_d     = size_q;
        osz_d      = osz_q;
        sq_d       = sq_q;
        col_d      = col_q;
        row_d      = row_q;
        map_d      = map_q;
        base_d     = base_q;
        row_base_d = row_base_q;
        map_base_d = map_base_q;
        wr_ptr_d   = wr_ptr_q;
        acc_d      = acc_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    mode_d     = poolMode;
                    maps_d     = mapsNumber;
                    size_d     = ADDR_SZ'(mapSize);
                    osz_d      = mapSize >> 1;
                    sq_d       = ADDR_SZ'(mapSize) * ADDR_SZ'(mapSize);
                    col_d      = '0;
                    row_d      = '0;
                    map_d      = '0;
                    base_d     = inAddress;
                    row_base_d = inAddress;
                    map_base_d = inAddress;
                    wr_ptr_d   = outAddress;
                end
            end
            S_ISSUE1: acc_d = rd_ext;
            S_ISSUE2,
            S_ISSUE3: acc_d = merged;
            S_WRITE: begin
                // output is dense, so the write pointer just steps by one
                wr_ptr_d = wr_ptr_q + ADDR_SZ'(1);
                if (!col_last) begin
                    col_d  = col_q + DATA_SZ'(1);
                    base_d = base_q + ADDR_SZ'(2);
                end else begin
                    col_d = '0;
                    if (!row_last) begin
                        // skip two input rows; for odd S the last row/column is never touched
                        row_d      = row_q + DATA_SZ'(1);
                        row_base_d = row_base_q + (size_q << 1);
                        base_d     = row_base_d;
                    end else begin
                        row_d      = '0;
                        map_d      = map_q + DATA_SZ'(1);
                        map_base_d = map_base_q + sq_q;
                        row_base_d = map_base_d;
                        base_d     = map_base_d;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // output logic: outputs are registered, decoded from the next state
    // ------------------------------------------------------------------
    always_comb begin
        re_d   = 1'b0;
        ra_d   = ra_q;
        we_d   = 1'b0;
        wa_d   = wa_q;
        wo_d   = wo_q;
        done_d = 1'b0;

        case (state_d)
            S_ISSUE0: begin re_d = 1'b1; ra_d = base_d; end
            S_ISSUE1: begin re_d = 1'b1; ra_d = base_d + ADDR_SZ'(1); end
            S_ISSUE2: begin re_d = 1'b1; ra_d = base_d + size_q; end
            S_ISSUE3: begin re_d = 1'b1; ra_d = base_d + size_q + ADDR_SZ'(1); end
            S_WRITE: begin
                // only reached from LAST, where merged includes the fourth word
                we_d = 1'b1;
                wa_d = wr_ptr_q;
                wo_d = result;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    assign readEnable  = re_q;
    assign readAddr    = ra_q;
    assign writeEnable = we_q;
    assign writeAddr   = wa_q;
    assign writeOut    = wo_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pooling_layer.sv
module tb_pooling_layer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        poolMode;
    logic [15:0] mapsNumber;
    logic [15:0] mapSize;
    logic [15:0] inAddress;
    logic [15:0] outAddress;
    logic        readEnable;
    logic [15:0] readAddr;
    logic [15:0] readData;
    logic        writeEnable;
    logic [15:0] writeAddr;
    logic [15:0] writeOut;
    logic        done;

    pooling_layer #(.DATA_SZ(16), .ADDR_SZ(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .poolMode   (poolMode),
        .mapsNumber (mapsNumber),
        .mapSize    (mapSize),
        .inAddress  (inAddress),
        .outAddress (outAddress),
        .readEnable (readEnable),
        .readAddr   (readAddr),
        .readData   (readData),
        .writeEnable(writeEnable),
        .writeAddr  (writeAddr),
        .writeOut   (writeOut),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic [15:0] mem [0:65535];
    logic [15:0] exp_rd [$];
    wr_t         exp_wr [$];
    logic [15:0] vals [$];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_reads = 0;
    int n_writes = 0;
    int n_done  = 0;
    int done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // memory: read data valid one cycle after the strobe
    always @(posedge clk) begin
        if (readEnable) readData <= mem[readAddr];
        if (writeEnable) mem[writeAddr] <= writeOut;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (readEnable || writeEnable) begin
                checks++;
                if (readEnable && writeEnable) begin
                    errors++;
                    $display("FAIL strobe_overlap: read and write both high at cycle %0d", cyc);
                end
            end
            if (readEnable) begin
                n_reads++;
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: addr %0h at cycle %0d", readAddr, cyc);
                end else begin
                    logic [15:0] e;
                    e = exp_rd.pop_front();
                    if (readAddr !== e) begin
                        errors++;
                        $display("FAIL read_addr: got %0h expected %0h", readAddr, e);
                    end
                end
            end
            if (writeEnable) begin
                n_writes++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h", writeAddr, writeOut);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    if (writeAddr !== w.a || writeOut !== w.d) begin
                        errors++;
                        $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                                 writeAddr, writeOut, w.a, w.d);
                    end
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // expected traffic for a run; pooled values come from the hand-filled vals queue
    task automatic push_run(input int maps, input int s, input logic [15:0] ina,
                            input logic [15:0] outa);
        int o;
        int idx;
        o = s / 2;
        idx = 0;
        for (int m = 0; m < maps; m++)
            for (int r = 0; r < o; r++)
                for (int c = 0; c < o; c++) begin
                    logic [15:0] b;
                    wr_t w;
                    b = 16'(int'(ina) + m*s*s + 2*r*s + 2*c);
                    exp_rd.push_back(b);
                    exp_rd.push_back(16'(b + 16'd1));
                    exp_rd.push_back(16'(b + 16'(s)));
                    exp_rd.push_back(16'(b + 16'(s) + 16'd1));
                    w.a = 16'(int'(outa) + idx);
                    w.d = vals[idx];
                    exp_wr.push_back(w);
                    idx++;
                end
    endtask

    task automatic do_run(input string name, input logic mode, input int maps, input int s,
                          input logic [15:0] ina, input logic [15:0] outa,
                          input int exp_lat, input int exp_n);
        int st, rd0, wr0, dn0, k;
        push_run(maps, s, ina, outa);
        rd0 = n_reads; wr0 = n_writes; dn0 = n_done;
        @(negedge clk);
        poolMode   = mode;
        mapsNumber = 16'(maps);
        mapSize    = 16'(s);
        inAddress  = ina;
        outAddress = outa;
        enable     = 1'b1;
        st = cyc;
        @(negedge clk);
        chk({name, "_first_read"}, {31'd0, readEnable}, {31'd0, exp_n > 0});
        // configuration changes after the start must be ignored
        poolMode   = ~mode;
        mapsNumber = 16'd7;
        mapSize    = 16'd9;
        inAddress  = ina ^ 16'h5555;
        outAddress = outa ^ 16'h0F0F;
        k = 0;
        while (n_done == dn0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (n_done == dn0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, k);
            exp_rd.delete();
            exp_wr.delete();
        end else begin
            chk({name, "_latency"}, 32'(done_cyc - st), 32'(exp_lat));
        end
        // enable stays high: no retrigger
        repeat (8) @(posedge clk);
        chk({name, "_done_count"}, 32'(n_done - dn0), 32'd1);
        chk({name, "_reads"}, 32'(n_reads - rd0), 32'(4 * exp_n));
        chk({name, "_writes"}, 32'(n_writes - wr0), 32'(exp_n));
        chk({name, "_queue_empty"}, 32'(exp_rd.size() + exp_wr.size()), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; poolMode = 1'b0;
        mapsNumber = '0; mapSize = '0; inAddress = '0; outAddress = '0;
        readData = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'(i);
        mem[16'h0300] = 16'hFFFF; mem[16'h0301] = 16'hFFFE;
        mem[16'h0302] = 16'hFFFD; mem[16'h0303] = 16'hFFFC;
        mem[16'h0320] = 16'hFFFB; mem[16'h0321] = 16'd3;
        mem[16'h0322] = 16'd3;    mem[16'h0323] = 16'hFFF8;
        for (int i = 0; i < 50; i++) mem[16'h0400 + i] = 16'(i);
        // row 4 / column 4 of each 5x5 map get distinct markers; they must never be read
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_readEnable", {31'd0, readEnable}, 32'd0);
        chk("rst_writeEnable", {31'd0, writeEnable}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_readAddr", {16'd0, readAddr}, 32'd0);
        chk("rst_writeAddr", {16'd0, writeAddr}, 32'd0);
        chk("rst_writeOut", {16'd0, writeOut}, 32'd0);

        vals = '{16'd5, 16'd7, 16'd13, 16'd15};
        do_run("max4", 1'b0, 1, 4, 16'h0100, 16'h0200, 25, 4);
        vals = '{16'd2, 16'd4, 16'd10, 16'd12};
        do_run("avg4", 1'b1, 1, 4, 16'h0100, 16'h0210, 25, 4);
        vals = '{16'hFFFD};
        do_run("avg_neg", 1'b1, 1, 2, 16'h0300, 16'h0310, 7, 1);
        vals = '{16'hFFFF};
        do_run("max_neg", 1'b0, 1, 2, 16'h0300, 16'h0311, 7, 1);
        vals = '{16'd3};
        do_run("max_mix", 1'b0, 1, 2, 16'h0320, 16'h0312, 7, 1);
        vals = '{16'd6, 16'd8, 16'd16, 16'd18, 16'd31, 16'd33, 16'd41, 16'd43};
        do_run("max_odd", 1'b0, 2, 5, 16'h0400, 16'h0500, 49, 8);
        vals = '{16'd3, 16'd5, 16'd13, 16'd15, 16'd28, 16'd30, 16'd38, 16'd40};
        do_run("avg_odd", 1'b1, 2, 5, 16'h0400, 16'h0510, 49, 8);
        vals.delete();
        do_run("degen_maps0", 1'b0, 0, 4, 16'h0100, 16'h0600, 1, 0);
        do_run("degen_s1", 1'b0, 1, 1, 16'h0100, 16'h0600, 1, 0);

        // reset during ISSUE2 of element 1
        begin
            int st;
            vals = '{16'd5, 16'd7, 16'd13, 16'd15};
            push_run(1, 4, 16'h0100, 16'h0220);
            @(negedge clk);
            poolMode = 1'b0; mapsNumber = 16'd1; mapSize = 16'd4;
            inAddress = 16'h0100; outAddress = 16'h0220; enable = 1'b1;
            st = cyc;
            while (cyc < st + 9) @(posedge clk);
            #1 reset = 1'b1; enable = 1'b0;
            @(posedge clk);
            #1 reset = 1'b0;
            chk("midrst_readEnable", {31'd0, readEnable}, 32'd0);
            chk("midrst_writeEnable", {31'd0, writeEnable}, 32'd0);
            chk("midrst_done", {31'd0, done}, 32'd0);
            chk("midrst_readAddr", {16'd0, readAddr}, 32'd0);
            chk("midrst_writeAddr", {16'd0, writeAddr}, 32'd0);
            chk("midrst_writeOut", {16'd0, writeOut}, 32'd0);
            exp_rd.delete();
            exp_wr.delete();
            begin
                int rd0, wr0, dn0;
                rd0 = n_reads; wr0 = n_writes; dn0 = n_done;
                repeat (6) @(posedge clk);
                chk("midrst_quiet", 32'((n_reads - rd0) + (n_writes - wr0) + (n_done - dn0)), 32'd0);
            end
        end
        vals = '{16'd5, 16'd7, 16'd13, 16'd15};
        do_run("after_rst", 1'b0, 1, 4, 16'h0100, 16'h0230, 25, 4);
        // second identical run after toggling enable
        do_run("rerun", 1'b0, 1, 4, 16'h0100, 16'h0230, 25, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
